fetch_prefetch_queue: RTL and testbench

- Parametrised successor to the single-register PC/fetch stage of our RV32 pipeline.
- Issues instruction-ROM reads through a request/response handshake with variable response latency and at most one request outstanding.
- Buffers up to DEPTH fetched {pc, instruction} pairs in an in-order queue, which decode drains through valid/ready.
- A redirect from the control unit flushes the queue and discards any in-flight response.

---
 rtl/fetch_prefetch_queue.sv | 136 +++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch stage with an in-order prefetch queue.
// Issues one ROM read at a time and buffers up to DEPTH {pc, instruction}
// pairs for decode. A redirect flushes the queue, and any response still
// in flight at that point is marked stale and thrown away when it returns.
module fetch_prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       rom_re_out,
    output logic [XLEN-1:0]            rom_addr_out,
    input  logic                       rom_ready_in,
    input  logic                       rom_valid_in,
    input  logic [31:0]                rom_data_in,
    input  logic                       jflag_in,
    input  logic [XLEN-1:0]            jaddr_in,
    output logic                       inst_valid_out,
    output logic [31:0]                inst_data_out,
    output logic [XLEN-1:0]            inst_pc_out,
    input  logic                       inst_ready_in,
    output logic [$clog2(DEPTH):0]     count_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  pend_pc_q, pend_pc_d;
    logic             pending_q, pending_d;
    logic             stale_q, stale_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [XLEN-1:0]  pc_mem_q   [DEPTH];
    logic [31:0]      inst_mem_q [DEPTH];

    logic accept;
    logic resp;
    logic push;
    logic pop;

    // Request and handshake qualifiers. The outstanding request already owns
    // a slot: while pending, count can only shrink, so a push never overflows.
    always_comb begin
        rom_re_out     = rst & ~jflag_in & ~pending_q & (count_q < CNT_W'(DEPTH));
        rom_addr_out   = fetch_pc_q;
        accept         = rom_re_out & rom_ready_in;
        resp           = rom_valid_in & pending_q;
        push           = resp & ~stale_q & ~jflag_in;
        inst_valid_out = rst & (count_q != '0);
        pop            = inst_valid_out & inst_ready_in;
        inst_data_out  = inst_mem_q[head_q];
        inst_pc_out    = pc_mem_q[head_q];
        count_out      = count_q;
    end

    // Next-state for fetch PC, pending/stale tracking and queue pointers.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        pending_d  = pending_q;
        stale_d    = stale_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (jflag_in) begin
            // Redirect wins over everything; the low address bits are dropped.
            fetch_pc_d = jaddr_in & ~XLEN'(3);
            count_d    = '0;
            head_d     = tail_q;
            if (pending_q) begin
                if (rom_valid_in) begin
                    pending_d = 1'b0;
                    stale_d   = 1'b0;
                end else begin
                    stale_d   = 1'b1;
                end
            end
        end else begin
            if (accept) begin
                pending_d  = 1'b1;
                pend_pc_d  = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (resp) begin
                pending_d = 1'b0;
                stale_d   = 1'b0;
            end
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= '0;
            pending_q  <= 1'b0;
            stale_q    <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            pending_q  <= pending_d;
            stale_q    <= stale_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Queue storage; only the tail slot is written, on a live response.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[tail_q]   <= pend_pc_q;
            inst_mem_q[tail_q] <= rom_data_in;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: a behavioural ROM, an expected in-order
// PC stream held in a queue, and a monitor that scores every consumed entry.
module tb_fetch_prefetch_queue;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT (RESET_PC = 0)
    logic        rst_n = 1'b0;
    logic        rom_re, rom_ready = 1'b0, rom_valid = 1'b0;
    logic [31:0] rom_addr, rom_data = '0;
    logic        jflag = 1'b0;
    logic [31:0] jaddr = '0;
    logic        inst_valid, inst_ready = 1'b0;
    logic [31:0] inst_data, inst_pc;
    logic [2:0]  count;

    // second DUT (RESET_PC = 0xFFFF_FFFC)
    logic        rst2 = 1'b0;
    logic        r2_re, r2_ready = 1'b1, r2_valid = 1'b0;
    logic [31:0] r2_addr, r2_data = '0;
    logic        r2_ivalid;
    logic [31:0] r2_idata, r2_ipc;
    logic [2:0]  r2_count;

    fetch_prefetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst_n),
        .rom_re_out(rom_re), .rom_addr_out(rom_addr), .rom_ready_in(rom_ready),
        .rom_valid_in(rom_valid), .rom_data_in(rom_data),
        .jflag_in(jflag), .jaddr_in(jaddr),
        .inst_valid_out(inst_valid), .inst_data_out(inst_data), .inst_pc_out(inst_pc),
        .inst_ready_in(inst_ready), .count_out(count)
    );

    fetch_prefetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst2),
        .rom_re_out(r2_re), .rom_addr_out(r2_addr), .rom_ready_in(r2_ready),
        .rom_valid_in(r2_valid), .rom_data_in(r2_data),
        .jflag_in(1'b0), .jaddr_in(32'h0),
        .inst_valid_out(r2_ivalid), .inst_data_out(r2_idata), .inst_pc_out(r2_ipc),
        .inst_ready_in(1'b0), .count_out(r2_count)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int pop_cnt = 0;

    // ROM model state
    bit          rom_busy = 1'b0;
    int          rom_cnt  = 0;
    logic [31:0] rom_addr_l = '0;
    int          lat = 1;
    int          ready_mode = 0;   // 0: ready, 1: random, 2: held low
    logic [31:0] acc_q[$];
    int          acc_cyc_q[$];

    bit          r2_pend = 1'b0;
    logic [31:0] r2_addr_l = '0;
    logic [31:0] r2_acc_q[$];

    // expected instruction stream (PCs in the order decode must see them)
    logic [31:0] exp_q[$];

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic stream_restart(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    // Monitor: every consumed head entry must be the next PC of the stream.
    always @(negedge clk) begin
        #2;
        if (rst_n && inst_valid && inst_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", inst_pc, 32'hxxxx_xxxx);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("pop_pc", inst_pc, e);
                chk("pop_data", inst_data, rom_fn(e));
                if (exp_q.size() < 8) begin
                    logic [31:0] last;
                    last = exp_q[exp_q.size() - 1];
                    for (int i = 1; i <= 16; i++) exp_q.push_back(last + 32'(4 * i));
                end
            end
        end
    end

    // One clock cycle: inputs are already set by the caller at this negedge.
    task automatic step();
        rom_valid = 1'b0;
        rom_data  = $urandom;
        if (rom_busy) begin
            if (rom_cnt == 0) begin
                rom_valid = 1'b1;
                rom_data  = rom_fn(rom_addr_l);
                rom_busy  = 1'b0;
            end else begin
                rom_cnt--;
            end
        end
        rom_ready = !rom_busy && (ready_mode == 0 ? 1'b1 :
                                  ready_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0);
        r2_valid = r2_pend;
        r2_data  = rom_fn(r2_addr_l);
        r2_pend  = 1'b0;
        #1;
        if (rom_re && rom_ready) begin
            rom_busy   = 1'b1;
            rom_cnt    = lat - 1;
            rom_addr_l = rom_addr;
            acc_q.push_back(rom_addr);
            acc_cyc_q.push_back(cyc);
        end
        if (r2_re && r2_ready) begin
            r2_pend   = 1'b1;
            r2_addr_l = r2_addr;
            r2_acc_q.push_back(r2_addr);
        end
        #2;
        if (!rst_n) stream_restart(32'h0000_0000);
        else if (jflag) stream_restart(jaddr & 32'hFFFF_FFFC);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        logic [31:0] a0;
        int          bad;
        int          k;
        int          p0;

        @(negedge clk);
        // reset: outputs held quiet
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_re", 32'(rom_re), 32'd0);
            chk("reset_valid", 32'(inst_valid), 32'd0);
        end
        chk("reset_count", 32'(count), 32'd0);

        // fill with 1-cycle ROM, decode stalled
        lat = 1; ready_mode = 0; inst_ready = 1'b0;
        acc_q.delete(); acc_cyc_q.delete();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("fill_nreq", 32'(acc_q.size()), 32'd4);
        if (acc_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("fill_addr", acc_q[i], 32'(4 * i));
                if (i > 0) chk("fill_spacing", 32'(acc_cyc_q[i] - acc_cyc_q[i-1]), 32'd2);
            end
        end
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_re_off", 32'(rom_re), 32'd0);
        chk("fill_head_pc", inst_pc, 32'h0);

        // single pop from a full queue
        acc_q.delete();
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("pop_count3", 32'(count), 32'd3);
        chk("refill_re", 32'(rom_re), 32'd1);
        chk("refill_addr", rom_addr, 32'h10);
        for (int i = 0; i < 6; i++) step();
        chk("refill_nreq", 32'(acc_q.size()), 32'd1);
        chk("refill_count", 32'(count), 32'd4);
        chk("refill_head", inst_pc, 32'h4);

        // redirect while 0x8 is outstanding on a 5-cycle ROM
        rst_n = 1'b0;
        step(); step();
        lat = 5; acc_q.delete();
        rst_n = 1'b1;
        k = 0;
        while (acc_q.size() < 3 && k < 60) begin step(); k++; end
        chk("flush_setup_nreq", 32'(acc_q.size()), 32'd3);
        if (acc_q.size() >= 3) chk("flush_setup_addr", acc_q[2], 32'h8);
        step(); step();
        jflag = 1'b1; jaddr = 32'h103;
        step();
        jflag = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(inst_valid), 32'd0);
        lat = 1; acc_q.delete();
        bad = 0; k = 0;
        while (acc_q.size() == 0 && k < 30) begin
            step(); k++;
            if (inst_valid) bad++;
        end
        chk("flush_stale_hidden", 32'(bad), 32'd0);
        chk("flush_nreq", 32'(acc_q.size() > 0), 32'd1);
        if (acc_q.size() > 0) chk("flush_target", acc_q[0], 32'h100);
        k = 0;
        while (!inst_valid && k < 10) begin step(); k++; end
        chk("flush_first_pc", inst_pc, 32'h100);

        // ROM stalls a request for three cycles
        inst_ready = 1'b1; ready_mode = 2;
        for (int i = 0; i < 4; i++) step();
        a0 = rom_addr;
        chk("stall_re", 32'(rom_re), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_re_hold", 32'(rom_re), 32'd1);
            chk("stall_addr_hold", rom_addr, a0);
        end
        ready_mode = 0; acc_q.delete();
        step();
        chk("stall_accept_addr", (acc_q.size() > 0) ? acc_q[0] : 32'hDEAD_BEEF, a0);
        chk("stall_next_addr", rom_addr, a0 + 32'd4);

        // continuous draining across pointer wrap
        p0 = pop_cnt;
        for (int i = 0; i < 40; i++) step();
        chk("stream_pops", 32'(pop_cnt - p0 >= 10), 32'd1);

        // randomized traffic with redirects and resets
        ready_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            lat = $urandom_range(1, 5);
            inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 399) == 0) begin
                jflag = 1'b0;
                rst_n = 1'b0;
                step(); step();
                chk("rand_reset_count", 32'(count), 32'd0);
                rst_n = 1'b1;
            end
            jflag = ($urandom_range(0, 99) < 3);
            jaddr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom;
            step();
        end
        jflag = 1'b0;

        // wrap of the fetch PC from a non-zero reset vector
        rst2 = 1'b1;
        k = 0;
        while (r2_acc_q.size() < 2 && k < 10) begin step(); k++; end
        chk("wrap_nreq", 32'(r2_acc_q.size()), 32'd2);
        if (r2_acc_q.size() >= 2) begin
            chk("wrap_first", r2_acc_q[0], 32'hFFFF_FFFC);
            chk("wrap_second", r2_acc_q[1], 32'h0000_0000);
        end
        k = 0;
        while (!r2_pend && k < 10) begin step(); k++; end
        rst2 = 1'b0;
        step();
        chk("midresp_rst_count", 32'(r2_count), 32'd0);
        chk("midresp_rst_valid", 32'(r2_ivalid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
